// File: rtl/redun_mont_pkg.sv
// Shared types and constants for the redundant-form Montgomery datapath.
// Holds the field modulus, word geometry and the redundant <-> canonical helpers.
package redun_mont_pkg;

   localparam int WRD_BITS      = 32;
   localparam int NUM_WRDS      = 33;
   localparam int DAT_BITS      = NUM_WRDS * WRD_BITS;
   localparam int EXT_BITS      = DAT_BITS + 2;
   localparam int NUM_WRDS_BITS = $clog2(NUM_WRDS);

   typedef logic [DAT_BITS-1:0] fe_t;
   // Each word carries one redundant bit above its WRD_BITS base bits.
   typedef logic [NUM_WRDS-1:0][WRD_BITS:0] redun0_t;

   localparam fe_t P = (fe_t'(1) << (DAT_BITS - 1)) - fe_t'(19);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_SEL  = 2'd2,
      ST_OUT  = 2'd3
   } redun_to_fe_state_t;

   function automatic logic [EXT_BITS-1:0] from_redun(input redun0_t r);
      logic [EXT_BITS-1:0] acc;
      acc = '0;
      for (int i = NUM_WRDS - 1; i >= 0; i--)
         acc = (acc << WRD_BITS) + EXT_BITS'(r[i]);
      return acc;
   endfunction

   function automatic redun0_t to_redun(input fe_t v);
      redun0_t r;
      for (int i = 0; i < NUM_WRDS; i++)
         r[i] = {1'b0, v[i*WRD_BITS +: WRD_BITS]};
      return r;
   endfunction

endpackage

// File: rtl/redun_to_fe_if.sv
// Handshake bundle between the redundant multiplier output and the converter.
interface redun_to_fe_if;
   import redun_mont_pkg::*;

   redun0_t i_redun;
   logic    i_val;
   logic    o_rdy;
   fe_t     o_dat;
   logic    o_val;
   logic    i_rdy;
   logic    o_err;

   modport slave  (input  i_redun, i_val, i_rdy, output o_rdy, o_dat, o_val, o_err);
   modport master (output i_redun, i_val, i_rdy, input  o_rdy, o_dat, o_val, o_err);
endinterface

// File: rtl/redun_to_fe.sv
// Word-serial redundant -> canonical converter with a single conditional subtract of P.
// Build option REDUN_TO_FE_OVF_CHECK_EN enables the sticky overflow flag on o_err.
//
// state | meaning
// IDLE  | waiting for input, o_rdy high
// RUN   | one word per cycle: resolve carry, form value and value-P
// SEL   | pick value or value-P, raise o_val
// OUT   | hold result until downstream takes it
module redun_to_fe
   import redun_mont_pkg::*;
(
   input logic          i_clk,
   input logic          i_rst_n,
   redun_to_fe_if.slave bus
);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_RUN  = ST_RUN;
   localparam logic [1:0] S_SEL  = ST_SEL;
   localparam logic [1:0] S_OUT  = ST_OUT;

   localparam logic [NUM_WRDS_BITS-1:0] CNT_LAST = NUM_WRDS_BITS'(NUM_WRDS - 1);

   logic [1:0]               state_q;
   logic [NUM_WRDS_BITS-1:0] cnt_q;
   logic [1:0]               carry_q;
   logic                     borrow_q;
   fe_t                      dat_q;
   logic                     val_q;
   logic                     rdy_q;

   redun0_t                  sh_q;
   fe_t                      value_q;
   fe_t                      diff_q;

   logic [WRD_BITS+1:0]      sum;
   logic [WRD_BITS-1:0]      p_wrd;
   logic [WRD_BITS:0]        dif;
   logic                     take_diff;
   logic                     accept;

   assign accept = (state_q == S_IDLE) && bus.i_val && rdy_q;

   always_comb begin
      p_wrd     = P[WRD_BITS*int'(cnt_q) +: WRD_BITS];
      sum       = (WRD_BITS+2)'(sh_q[0]) + (WRD_BITS+2)'(carry_q);
      dif       = {1'b0, sum[WRD_BITS-1:0]} - {1'b0, p_wrd} - (WRD_BITS+1)'(borrow_q);
      // A carry past the top word means value >= 2^DAT_BITS > P, so the difference wins.
      take_diff = (carry_q != 2'd0) || !borrow_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         carry_q  <= '0;
         borrow_q <= 1'b0;
         dat_q    <= '0;
         val_q    <= 1'b0;
         rdy_q    <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  state_q  <= S_RUN;
                  cnt_q    <= '0;
                  carry_q  <= '0;
                  borrow_q <= 1'b0;
                  rdy_q    <= 1'b0;
               end
            end
            S_RUN: begin
               carry_q  <= sum[WRD_BITS+1:WRD_BITS];
               borrow_q <= dif[WRD_BITS];
               if (cnt_q == CNT_LAST) begin
                  cnt_q   <= '0;
                  state_q <= S_SEL;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_SEL: begin
               dat_q   <= take_diff ? diff_q : value_q;
               val_q   <= 1'b1;
               state_q <= S_OUT;
            end
            S_OUT: begin
               if (bus.i_rdy) begin
                  val_q   <= 1'b0;
                  rdy_q   <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Wide datapath registers need no reset: every field is rewritten before it is used.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         sh_q <= bus.i_redun;
      end else if (state_q == S_RUN) begin
         sh_q    <= {{(WRD_BITS+1){1'b0}}, sh_q[NUM_WRDS-1:1]};
         value_q <= {sum[WRD_BITS-1:0], value_q[DAT_BITS-1:WRD_BITS]};
         diff_q  <= {dif[WRD_BITS-1:0], diff_q[DAT_BITS-1:WRD_BITS]};
      end
   end

`ifdef REDUN_TO_FE_OVF_CHECK_EN
   logic err_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         err_q <= 1'b0;
      else if ((state_q == S_SEL) && (carry_q != 2'd0))
         err_q <= 1'b1;
   end

   assign bus.o_err = err_q;
`else
   assign bus.o_err = 1'b0;
`endif

   assign bus.o_dat = dat_q;
   assign bus.o_val = val_q;
   assign bus.o_rdy = rdy_q;

endmodule

// File: tb/tb_redun_to_fe.sv
// Directed and random checks of redun_to_fe against hand-computed and modulo-P expectations.
module tb_redun_to_fe;
   import redun_mont_pkg::*;

`ifdef REDUN_TO_FE_OVF_CHECK_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic i_clk   = 1'b0;
   logic i_rst_n = 1'b0;

   redun_to_fe_if bus();

   redun_to_fe dut (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .bus    (bus)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      redun0_t in;
      fe_t     exp;
      string   name;
   } vec_t;

   vec_t vecs[7];
   int   n_cmp   = 0;
   int   n_bad   = 0;
   logic err_exp = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chk_fe(input string name, input fe_t act, input fe_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got low128 %h want low128 %h (upper bits differ: %0d)",
                  name, act[127:0], exp[127:0], act[DAT_BITS-1:128] !== exp[DAT_BITS-1:128]);
      end
   endtask

   // Entered and left on a negedge; returns after the accepting posedge's following negedge.
   task automatic send(input redun0_t r);
      int t = 0;
      while (!bus.o_rdy && t < 100) begin
         @(negedge i_clk);
         t++;
      end
      chk("send_rdy", 64'(bus.o_rdy), 64'd1);
      bus.i_redun = r;
      bus.i_val   = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      bus.i_val = 1'b0;
   endtask

   // lat = index of the posedge (acceptance edge = 0) at which downstream first samples o_val.
   task automatic wait_out(output int lat);
      int edges = 0;
      while (!bus.o_val && edges < 60) begin
         @(negedge i_clk);
         edges++;
      end
      lat = edges + 1;
   endtask

   task automatic txn(input redun0_t r, input fe_t exp, input string name);
      int lat;
      send(r);
      wait_out(lat);
      chk({name, "_lat"}, 64'(lat), 64'(NUM_WRDS + 2));
      chk_fe({name, "_dat"}, bus.o_dat, exp);
      chk({name, "_err"}, 64'(bus.o_err), 64'(err_exp));
      @(negedge i_clk);
      chk({name, "_done_val"}, 64'(bus.o_val), 64'd0);
      chk({name, "_done_rdy"}, 64'(bus.o_rdy), 64'd1);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      redun0_t r;
      fe_t     v;
      fe_t     two_p;
      int      lat;

      bus.i_redun = '0;
      bus.i_val   = 1'b0;
      bus.i_rdy   = 1'b1;

      vecs[0].in = '0;  vecs[0].exp = '0;  vecs[0].name = "zero";
      vecs[1].in = '0;  vecs[1].in[0] = 33'h1_0000_0000;
      vecs[1].exp = fe_t'(1) << 32;  vecs[1].name = "w0_carry";
      vecs[2].in = '0;
      for (int i = 0; i < 4; i++) vecs[2].in[i] = 33'h1_FFFF_FFFF;
      vecs[2].exp = fe_t'(from_redun(vecs[2].in));  vecs[2].name = "chain";
      vecs[3].in = to_redun(P);  vecs[3].exp = '0;  vecs[3].name = "eq_p";
      vecs[4].in = to_redun(P - fe_t'(1));  vecs[4].exp = P - fe_t'(1);  vecs[4].name = "p_m1";
      vecs[5].in = to_redun((P << 1) - fe_t'(1));  vecs[5].exp = P - fe_t'(1);  vecs[5].name = "2p_m1";
      // P+5 with a borrowed unit pushed into word 0's redundant bit
      vecs[6].in = to_redun(P + fe_t'(5));
      vecs[6].in[0][WRD_BITS] = 1'b1;
      vecs[6].in[1] = vecs[6].in[1] - 33'd1;
      vecs[6].exp = fe_t'(5);  vecs[6].name = "redun_p5";

      #12;
      chk("rst_rdy", 64'(bus.o_rdy), 64'd1);
      chk("rst_val", 64'(bus.o_val), 64'd0);
      chk("rst_err", 64'(bus.o_err), 64'd0);
      chk_fe("rst_dat", bus.o_dat, '0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      for (int k = 0; k < 7; k++) txn(vecs[k].in, vecs[k].exp, vecs[k].name);

      // Backpressure: result must hold for 10 cycles, then exactly one transfer.
      bus.i_rdy = 1'b0;
      send(vecs[6].in);
      wait_out(lat);
      chk("bp_lat", 64'(lat), 64'(NUM_WRDS + 2));
      for (int c = 0; c < 10; c++) begin
         @(negedge i_clk);
         chk("bp_hold_val", 64'(bus.o_val), 64'd1);
         chk("bp_hold_rdy", 64'(bus.o_rdy), 64'd0);
         chk_fe("bp_hold_dat", bus.o_dat, fe_t'(5));
      end
      bus.i_rdy = 1'b1;
      @(negedge i_clk);
      chk("bp_after_val", 64'(bus.o_val), 64'd0);
      chk("bp_after_rdy", 64'(bus.o_rdy), 64'd1);

      // Reset pulse in the middle of RUN.
      send(vecs[2].in);
      repeat (11) @(posedge i_clk);
      #1;
      chk("midrun_rdy_low", 64'(bus.o_rdy), 64'd0);
      #1 i_rst_n = 1'b0;
      #1;
      chk("midrun_rst_val", 64'(bus.o_val), 64'd0);
      chk("midrun_rst_rdy", 64'(bus.o_rdy), 64'd1);
      chk("midrun_rst_err", 64'(bus.o_err), 64'd0);
      err_exp = 1'b0;
      #2 i_rst_n = 1'b1;
      @(negedge i_clk);
      txn(vecs[6].in, fe_t'(5), "post_rst");

      // Carry out of the top word: value wraps to 0, SEL picks 0-P.
      r = '0;
      r[NUM_WRDS-2] = 33'h1_0000_0000;
      r[NUM_WRDS-1] = 33'h1_FFFF_FFFF;
      err_exp = OVF_EN;
      txn(r, fe_t'(0) - P, "ovf");
      txn(vecs[0].in, '0, "ovf_sticky");

      two_p = P << 1;
      for (int n = 0; n < 1000; n++) begin
         for (int w = 0; w < NUM_WRDS; w++) v[w*WRD_BITS +: WRD_BITS] = $urandom;
         v = v % two_p;
         r = to_redun(v);
         for (int i = 0; i < NUM_WRDS - 1; i++) begin
            if ($urandom_range(0, 1) == 1 && !r[i][WRD_BITS] && r[i+1] != '0) begin
               r[i][WRD_BITS] = 1'b1;
               r[i+1] = r[i+1] - 33'd1;
            end
         end
         txn(r, v % P, "rand");
      end

      #2 i_rst_n = 1'b0;
      #1;
      chk("final_rst_err", 64'(bus.o_err), 64'd0);
      chk("final_rst_rdy", 64'(bus.o_rdy), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
